// File: rtl/timer_defs.sv
// rtl/timer_defs.sv - shared encodings for the countdown interrupt timer
//
// Holds the FSM state encoding, bus word offsets, CTRL field positions
// and MODE values used by timer_irq.

package timer_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM       = 3;

  localparam logic [1:0] MODE_ONE_SHOT    = 2'b00;
  localparam logic [1:0] MODE_AUTO_RELOAD = 2'b01;

  // Only the exact auto-reload code reloads; 10 and 11 fall back to one-shot.
  function automatic logic is_auto_reload(input logic [1:0] mode);
    return mode == MODE_AUTO_RELOAD;
  endfunction

endpackage

// File: rtl/timer_irq.sv
// rtl/timer_irq.sv - memory-mapped countdown timer driving one CP0 interrupt line
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  asynchronous active-low reset
//   addr   word offset: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
//   we     write strobe for the current cycle
//   wdata  write data
//   rdata  combinational read of the register selected by addr
//   irq    interrupt request, pending AND CTRL.IM, from registers only

module timer_irq
  import timer_defs::*;
#(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         addr,
  input  logic               we,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               irq
);

  logic [3:0]         ctrl_q;
  logic [COUNT_W-1:0] preset_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               pending_q;
  state_e             state_q;
  state_e             state_d;

  logic               wr_ctrl;
  logic               wr_preset;
  logic               en_clr;
  logic               pend_set;
  logic               ctrl_en;
  logic               auto_mode;

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);
  assign ctrl_en   = ctrl_q[CTRL_EN];
  assign auto_mode = is_auto_reload(ctrl_q[CTRL_MODE_MSB:CTRL_MODE_LSB]);

  // All FSM decisions look at the registered (pre-write) CTRL/PRESET values.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    en_clr   = 1'b0;
    pend_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_en) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          state_d = ST_IDLE;
        end else if (count_q <= COUNT_W'(1)) begin
          // PRESET of 0 or 1 both expire on the first CNT cycle.
          count_d = '0;
          state_d = ST_INT;
        end else begin
          count_d = count_q - COUNT_W'(1);
        end
      end
      ST_INT: begin
        pend_set = 1'b1;
        if (auto_mode) begin
          state_d = ST_LOAD;
        end else begin
          en_clr  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // A CPU write to CTRL wins over the one-shot EN clear, so a rewrite in
  // the INT cycle keeps the new EN and restarts counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
    end else if (wr_ctrl) begin
      ctrl_q <= wdata[3:0];
    end else if (en_clr) begin
      ctrl_q[CTRL_EN] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset_q <= '0;
    end else if (wr_preset) begin
      preset_q <= wdata[COUNT_W-1:0];
    end
  end

  // The acknowledge (CTRL/PRESET write) beats a coincident expiry: the CPU
  // is reprogramming the timer, so that expiry is intentionally dropped.
  // In auto-reload mode a set pending lasts exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= 1'b0;
    end else if (wr_ctrl || wr_preset) begin
      pending_q <= 1'b0;
    end else if (pend_set) begin
      pending_q <= 1'b1;
    end else if (auto_mode) begin
      pending_q <= 1'b0;
    end
  end

  assign irq = pending_q & ctrl_q[CTRL_IM];

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_CTRL:   rdata = {28'd0, ctrl_q};
      ADDR_PRESET: rdata = 32'(preset_q);
      ADDR_COUNT:  rdata = 32'(count_q);
      default:     rdata = '0;
    endcase
  end

endmodule
